mod_counter: RTL and testbench

- Parametrised up/down modulo counter with enable, synchronous load/clear, wrap or saturate mode, terminal-count pulse and sticky overflow flag.
- Next-generation replacement for the free-running counter used in timers, frame/line counters and rate generators.
- Fully synchronous; single clock domain.

---
 rtl/mod_counter.sv | 100 ++++++++++
 tb/tb_mod_counter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - up/down modulo counter with wrap/saturate, tc pulse and sticky overflow
// Optional prescaler on the enable path is built when COUNTER_PRESCALE_EN is defined.
module mod_counter #(
    parameter int WIDTH    = 8,
    parameter int MAX      = 255,
    parameter int SATURATE = 0
`ifdef COUNTER_PRESCALE_EN
    ,
    parameter int PRESCALE_WIDTH = 4
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    input  logic             up,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PRESCALE_WIDTH-1:0] prescale_div,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    logic [WIDTH-1:0] load_clamped;
    logic             step;
    logic             at_max;
    logic             at_zero;

    // A full-range counter can never be loaded out of range, so skip the compare.
    generate
        if (MAX == (2 ** WIDTH) - 1) begin : g_no_clamp
            assign load_clamped = load_value;
        end else begin : g_clamp
            assign load_clamped = (load_value > MAX_V) ? MAX_V : load_value;
        end
    endgenerate

    assign at_max  = (count == MAX_V);
    assign at_zero = (count == '0);

`ifdef COUNTER_PRESCALE_EN
    logic [PRESCALE_WIDTH-1:0] prescaler;

    assign step = en && (prescaler == prescale_div);

    always_ff @(posedge clk) begin
        if (!rst_n || clear || load || step) begin
            prescaler <= '0;
        end else if (en) begin
            prescaler <= prescaler + PRESCALE_WIDTH'(1);
        end
    end
`else
    assign step = en;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            tc       <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            tc       <= 1'b0;
            overflow <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            tc    <= 1'b0;
        end else if (step) begin
            if (up) begin
                if (at_max) begin
                    count    <= (SATURATE != 0) ? MAX_V : '0;
                    tc       <= 1'b1;
                    overflow <= 1'b1;
                end else begin
                    count <= count + ONE_V;
                    tc    <= 1'b0;
                end
            end else begin
                if (at_zero) begin
                    count    <= (SATURATE != 0) ? '0 : MAX_V;
                    tc       <= 1'b1;
                    overflow <= 1'b1;
                end else begin
                    count <= count - ONE_V;
                    tc    <= 1'b0;
                end
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - table-driven scoreboard bench for mod_counter (three configurations)
module tb_mod_counter;

    typedef struct {
        int         dut;
        logic       rst_n;
        logic       clear;
        logic       load;
        logic [3:0] lv;
        logic       en;
        logic       up;
        logic [3:0] ec;
        logic       etc;
        logic       eovf;
    } vec_t;

    typedef struct {
        int         dut;
        int         idx;
        logic [3:0] ec;
        logic       etc;
        logic       eovf;
    } exp_t;

    logic       clk;
    logic       rst_n_v [3];
    logic       clear_v [3];
    logic       load_v  [3];
    logic [3:0] lv_v    [3];
    logic       en_v    [3];
    logic       up_v    [3];
    logic [3:0] cnt_v   [3];
    logic       tc_v    [3];
    logic       ovf_v   [3];
`ifdef COUNTER_PRESCALE_EN
    logic [3:0] cur_pdiv;
`endif

    int   n_vec;
    int   n_bad;
    exp_t sb [$];
    vec_t tbl [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dut 0: MAX=9 wrap, dut 1: MAX=9 saturate, dut 2: full 4-bit range wrap
    mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n_v[0]), .clear(clear_v[0]), .load(load_v[0]),
        .load_value(lv_v[0]), .en(en_v[0]), .up(up_v[0]),
`ifdef COUNTER_PRESCALE_EN
        .prescale_div(cur_pdiv),
`endif
        .count(cnt_v[0]), .tc(tc_v[0]), .overflow(ovf_v[0])
    );

    mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n_v[1]), .clear(clear_v[1]), .load(load_v[1]),
        .load_value(lv_v[1]), .en(en_v[1]), .up(up_v[1]),
`ifdef COUNTER_PRESCALE_EN
        .prescale_div(cur_pdiv),
`endif
        .count(cnt_v[1]), .tc(tc_v[1]), .overflow(ovf_v[1])
    );

    mod_counter #(.WIDTH(4), .MAX(15), .SATURATE(0)) dut_full (
        .clk(clk), .rst_n(rst_n_v[2]), .clear(clear_v[2]), .load(load_v[2]),
        .load_value(lv_v[2]), .en(en_v[2]), .up(up_v[2]),
`ifdef COUNTER_PRESCALE_EN
        .prescale_div(cur_pdiv),
`endif
        .count(cnt_v[2]), .tc(tc_v[2]), .overflow(ovf_v[2])
    );

    function automatic vec_t mk(int d, logic r, logic c, logic l, logic [3:0] lv,
                                logic e, logic u, logic [3:0] ec, logic t, logic o);
        vec_t v;
        v.dut = d; v.rst_n = r; v.clear = c; v.load = l; v.lv = lv;
        v.en = e; v.up = u; v.ec = ec; v.etc = t; v.eovf = o;
        return v;
    endfunction

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            rst_n_v[i] = 1'b1; clear_v[i] = 1'b0; load_v[i] = 1'b0;
            lv_v[i] = 4'd0; en_v[i] = 1'b0; up_v[i] = 1'b0;
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        @(negedge clk);
        idle_all();
        rst_n_v[v.dut] = v.rst_n;
        clear_v[v.dut] = v.clear;
        load_v[v.dut]  = v.load;
        lv_v[v.dut]    = v.lv;
        en_v[v.dut]    = v.en;
        up_v[v.dut]    = v.up;
        e.dut = v.dut; e.idx = idx; e.ec = v.ec; e.etc = v.etc; e.eovf = v.eovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        n_vec++;
        if (cnt_v[got.dut] !== got.ec || tc_v[got.dut] !== got.etc || ovf_v[got.dut] !== got.eovf) begin
            n_bad++;
            $display("FAIL vec%0d dut%0d: got count=%0d tc=%0b ovf=%0b, expected count=%0d tc=%0b ovf=%0b",
                     got.idx, got.dut, cnt_v[got.dut], tc_v[got.dut], ovf_v[got.dut],
                     got.ec, got.etc, got.eovf);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        idle_all();
`ifdef COUNTER_PRESCALE_EN
        cur_pdiv = 4'd0;
`endif

        // dut 0: reset, up wrap, reset mid-count, clamp/priority, down wrap, direction changes
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 12; k++)
            tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 4'(k % 10), k == 10, k >= 10));
        tbl.push_back(mk(0, 1, 0, 1, 6, 0, 0, 6, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 7, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 14, 1, 1, 9, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 1, 9, 0, 0, 9, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 5, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 9, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 9, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 9, 1, 1));
        tbl.push_back(mk(0, 1, 0, 1, 10, 0, 0, 9, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 4, 1, 0, 4, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 3, 0, 1));

        // dut 1: saturate at both ends, tc held high on repeated boundary hits
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 2, 0, 0, 2, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 1, 8, 0, 0, 8, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 9, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 9, 1, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 9, 1, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 8, 0, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));

        // dut 2: MAX = 2**WIDTH-1 wraps cleanly in both directions
        tbl.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2, 1, 0, 1, 15, 0, 0, 15, 0, 0));
        tbl.push_back(mk(2, 1, 0, 0, 0, 1, 1, 0, 1, 1));
        tbl.push_back(mk(2, 1, 0, 0, 0, 1, 0, 15, 1, 1));
        tbl.push_back(mk(2, 1, 0, 0, 0, 1, 0, 14, 0, 1));
        tbl.push_back(mk(2, 1, 1, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i], i);

        // continuous up-count across a full-range wrap
        for (int k = 1; k <= 20; k++)
            apply(mk(2, 1, 0, 0, 0, 1, 1, 4'(k % 16), k == 16, k >= 16), 100 + k);

`ifdef COUNTER_PRESCALE_EN
        // divide-by-3 stepping, then load restarts the spacing
        cur_pdiv = 4'd2;
        apply(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0), 200);
        for (int k = 1; k <= 9; k++)
            apply(mk(0, 1, 0, 0, 0, 1, 1, 4'(k / 3), 0, 0), 200 + k);
        apply(mk(0, 1, 0, 0, 0, 1, 1, 3, 0, 0), 210);
        apply(mk(0, 1, 0, 1, 5, 0, 0, 5, 0, 0), 211);
        apply(mk(0, 1, 0, 0, 0, 1, 1, 5, 0, 0), 212);
        apply(mk(0, 1, 0, 0, 0, 1, 1, 5, 0, 0), 213);
        apply(mk(0, 1, 0, 0, 0, 1, 1, 6, 0, 0), 214);
        cur_pdiv = 4'd0;
        apply(mk(0, 1, 0, 0, 0, 1, 1, 7, 0, 0), 215);
        apply(mk(0, 1, 0, 0, 0, 1, 1, 8, 0, 0), 216);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
